// File: rtl/mem_transfer_ctrl.sv
// mem_transfer_ctrl: fills memory A from a valid/ready source, copies A into B,
// and accumulates a modulo-2^DATA_W checksum of the words written to B.
module mem_transfer_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              DataValid,
  output logic              DataReady,
  output logic              MemReset,
  output logic              IncA,
  output logic              WEA,
  output logic [DATA_W-1:0] DataInA,
  input  logic [DATA_W-1:0] Dout1,
  output logic              IncB,
  output logic              WEB,
  output logic [DATA_W-1:0] DataInB,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Checksum
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FILL  = 3'd2,
    S_RWND  = 3'd3,
    S_XFER  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  fill_cnt, fill_cnt_n;
  logic [CNT_W-1:0]  xfer_cnt, xfer_cnt_n;
  logic              ready_n, mem_reset_n, inc_a_n, we_a_n, inc_b_n, we_b_n;
  logic              busy_n, done_n;
  logic [DATA_W-1:0] data_in_a_n, data_in_b_n, checksum_n;

  // Next state plus the value every registered output takes after the next edge
  always_comb begin
    state_n     = state;
    fill_cnt_n  = fill_cnt;
    xfer_cnt_n  = xfer_cnt;
    data_in_a_n = DataInA;
    data_in_b_n = DataInB;
    checksum_n  = Checksum;
    ready_n     = 1'b0;
    inc_a_n     = 1'b0;
    we_a_n      = 1'b0;
    inc_b_n     = 1'b0;
    we_b_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          state_n    = S_CLR;
          checksum_n = '0;
        end
      end
      S_CLR: begin
        state_n    = S_FILL;
        fill_cnt_n = '0;
        ready_n    = 1'b1;
      end
      S_FILL: begin
        ready_n = 1'b1;
        if (DataValid && DataReady) begin
          // accepted word is written to A during the following cycle
          data_in_a_n = DataIn;
          inc_a_n     = 1'b1;
          we_a_n      = 1'b1;
          if (fill_cnt == LAST_IDX) begin
            fill_cnt_n = '0;
            ready_n    = 1'b0;
            state_n    = S_RWND;
          end else begin
            fill_cnt_n = fill_cnt + CNT_W'(1);
          end
        end
      end
      S_RWND: begin
        state_n    = S_XFER;
        xfer_cnt_n = '0;
        inc_a_n    = 1'b1;
      end
      S_XFER: begin
        // A was read on the previous falling edge; forward that word to B
        data_in_b_n = Dout1;
        checksum_n  = Checksum + Dout1;
        inc_b_n     = 1'b1;
        we_b_n      = 1'b1;
        if (xfer_cnt == LAST_IDX) begin
          xfer_cnt_n = '0;
          state_n    = S_DRAIN;
        end else begin
          xfer_cnt_n = xfer_cnt + CNT_W'(1);
          inc_a_n    = 1'b1;
        end
      end
      S_DRAIN: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    mem_reset_n = (state_n == S_CLR) || (state_n == S_RWND);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      fill_cnt  <= '0;
      xfer_cnt  <= '0;
      DataReady <= 1'b0;
      MemReset  <= 1'b1;
      IncA      <= 1'b0;
      WEA       <= 1'b0;
      DataInA   <= '0;
      IncB      <= 1'b0;
      WEB       <= 1'b0;
      DataInB   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Checksum  <= '0;
    end else begin
      state     <= state_n;
      fill_cnt  <= fill_cnt_n;
      xfer_cnt  <= xfer_cnt_n;
      DataReady <= ready_n;
      MemReset  <= mem_reset_n;
      IncA      <= inc_a_n;
      WEA       <= we_a_n;
      DataInA   <= data_in_a_n;
      IncB      <= inc_b_n;
      WEB       <= we_b_n;
      DataInB   <= data_in_b_n;
      Busy      <= busy_n;
      Done      <= done_n;
      Checksum  <= checksum_n;
    end
  end

endmodule

// File: tb/tb_mem_transfer_ctrl.sv
// Bench for mem_transfer_ctrl: models both memories and checks each run's
// B contents, checksum, write count and Done/Busy timing against the source words.
module tb_mem_transfer_ctrl;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 8;

  logic              clock = 1'b0;
  logic              Reset;
  logic              Start;
  logic [DATA_W-1:0] DataIn;
  logic              DataValid;
  logic              DataReady;
  logic              MemReset;
  logic              IncA, WEA, IncB, WEB;
  logic [DATA_W-1:0] DataInA, DataInB;
  logic [DATA_W-1:0] Dout1 = '0;
  logic              Busy, Done;
  logic [DATA_W-1:0] Checksum;

  mem_transfer_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .Reset(Reset), .Start(Start), .DataIn(DataIn),
    .DataValid(DataValid), .DataReady(DataReady), .MemReset(MemReset),
    .IncA(IncA), .WEA(WEA), .DataInA(DataInA), .Dout1(Dout1),
    .IncB(IncB), .WEB(WEB), .DataInB(DataInB), .Busy(Busy),
    .Done(Done), .Checksum(Checksum)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [CNT_W-1:0]  addr_a = '0;
  logic [CNT_W-1:0]  addr_b = '0;
  logic [DATA_W-1:0] words [DEPTH];

  always @(posedge clock) cyc <= cyc + 1;

  // Falling-edge memory stages: write or read at the address, then rewind or post-increment
  always @(negedge clock) begin
    if (WEA) mem_a[addr_a] = DataInA;
    else if (IncA) Dout1 = mem_a[addr_a];
    if (MemReset) addr_a = '0;
    else if (IncA) addr_a = addr_a + 3'd1;
    if (WEB) mem_b[addr_b] = DataInB;
    if (MemReset) addr_b = '0;
    else if (IncB) addr_b = addr_b + 3'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full run: times are counted in cycles from the edge that samples Start
  task automatic run_xfer(input int stall_at, input int stall_len, input int pct,
                          input bit start_mid, input int abort_at);
    int c0, idx, stalls, stall_rem, web_cnt, done_cnt, done_cyc, fall_cyc, total;
    bit prev_valid, fell, st;
    total = 0;
    foreach (words[i]) total += int'(words[i]);
    @(negedge clock);
    Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    c0 = cyc; web_cnt = 0; done_cnt = 0; done_cyc = -1; fall_cyc = -1;
    stalls = 0; stall_rem = stall_len; idx = 0; prev_valid = 1'b0; fell = 1'b0;
    check("clr_memreset", 32'(MemReset), 32'd1);
    check("clr_busy", 32'(Busy), 32'd1);
    check("clr_checksum", 32'(Checksum), 32'd0);
    @(negedge clock);
    for (int k = 0; k < 64; k++) begin
      if (WEB) web_cnt++;
      if (Done) done_cnt++;
      if (prev_valid) idx++;
      check("fill_ready", 32'(DataReady), 32'(idx < DEPTH));
      if (idx == DEPTH) begin
        DataValid = 1'b0;
        break;
      end
      st = 1'b0;
      if (idx == stall_at && stall_rem > 0) begin
        st = 1'b1;
        stall_rem--;
      end else if (pct > 0 && stalls < 10 && $urandom_range(99) < pct) begin
        st = 1'b1;
      end
      if (st) begin
        DataValid = 1'b0;
        DataIn    = 8'($urandom);
        stalls++;
      end else begin
        DataValid = 1'b1;
        DataIn    = words[idx];
      end
      prev_valid = DataValid;
      @(negedge clock);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (abort_at > 0 && cyc == c0 + abort_at) begin
        Reset = 1'b0;
        DataValid = 1'b0;
        #1;
        check("abort_memreset", 32'(MemReset), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_ctrl", 32'({IncA, WEA, IncB, WEB, DataReady, Done}), 32'd0);
        check("abort_data", 32'({Checksum, DataInA, DataInB}), 32'd0);
        repeat (2) @(negedge clock);
        Reset = 1'b1;
        @(negedge clock);
        check("abort_idle", 32'({Busy, MemReset}), 32'd0);
        return;
      end
      Start     = start_mid && (cyc == c0 + 13 + stalls);
      DataValid = 1'($urandom_range(1));
      DataIn    = 8'($urandom);
      if (WEB) web_cnt++;
      if (Done) begin
        done_cnt++;
        done_cyc = cyc - c0;
      end
      if (!Busy) begin
        fell = 1'b1;
        fall_cyc = cyc - c0;
        break;
      end
    end
    Start = 1'b0;
    DataValid = 1'b0;
    check("busy_fell", 32'(fell), 32'd1);
    check("busy_fall_cycle", 32'(fall_cyc), 32'(20 + stalls));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(19 + stalls));
    check("b_write_count", 32'(web_cnt), 32'(DEPTH));
    check("checksum", 32'(Checksum), 32'(total % 256));
    for (int i = 0; i < DEPTH; i++) check($sformatf("mem_b[%0d]", i), 32'(mem_b[i]), 32'(words[i]));
    repeat (2) @(negedge clock);
    check("idle_hold", 32'({Busy, Done}), 32'd0);
    check("checksum_hold", 32'(Checksum), 32'(total % 256));
  endtask

  task automatic rand_words();
    foreach (words[i]) words[i] = 8'($urandom);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; DataValid = 1'b0; DataIn = '0;
    #1 Reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_memreset", 32'(MemReset), 32'd1);
    check("rst_ctrl", 32'({IncA, WEA, IncB, WEB, DataReady, Busy, Done}), 32'd0);
    check("rst_data", 32'({DataInA, DataInB, Checksum}), 32'd0);
    Reset = 1'b1;
    @(negedge clock);
    check("rel_memreset", 32'(MemReset), 32'd0);
    check("rel_busy", 32'(Busy), 32'd0);

    foreach (words[i]) words[i] = 8'(i + 1);
    run_xfer(-1, 0, 0, 1'b0, 0);
    run_xfer(3, 3, 0, 1'b0, 0);
    foreach (words[i]) words[i] = 8'hFF;
    run_xfer(-1, 0, 0, 1'b1, 0);
    rand_words();
    run_xfer(-1, 0, 0, 1'b0, 13);
    rand_words();
    run_xfer(-1, 0, 0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      rand_words();
      run_xfer(-1, 0, 30, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
